fir_interp_poly: RTL and testbench

//  Parametrised polyphase interpolating FIR. Upsamples by L with an N_TAPS-tap real filter
//  (RC/RRC pulse shaping ahead of the DAC path) from a valid/ready input stream.

---
 rtl/fir_interp_poly.sv | 215 +++++++++++++++++++++
 tb/tb_fir_interp_poly.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fir_interp_poly.sv
// Polyphase interpolating FIR (upsample by L) with ZOH / zero-stuff bypass modes,
// a one-entry input hold buffer, half-up rounding, saturation and a 3-stage output pipeline.
module fir_interp_poly #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int L      = 10,
  parameter int PT     = 5,
  parameter int N_TAPS = 41,
  parameter int FRAC   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic                     din_vld,
  output logic                     din_rdy,
  input  logic signed [DW-1:0]     din,
  input  logic [1:0]               mode,
  input  logic [N_TAPS*CW-1:0]     tap,
  input  logic                     clr_err,
  output logic signed [DW-1:0]     dout,
  output logic                     dout_vld,
  output logic                     underrun
);

  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int AW = DW + CW + $clog2(PT) + 1;

  localparam logic [1:0] MODE_ZOH = 2'd1;
  localparam logic [1:0] MODE_ZST = 2'd2;

  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // input side state
  logic [PW-1:0]          r_ph;
  logic signed [DW-1:0]   r_sr [PT];
  logic signed [DW-1:0]   r_buf;
  logic                   r_buf_full;
  logic                   r_underrun;

  logic                   w_consume;
  logic                   w_starve;
  logic                   w_wr;
  logic signed [DW-1:0]   w_new;

  // stage 1
  logic                   r_v1;
  logic [1:0]             r_mode1;
  logic                   r_ph0_1;
  logic signed [DW-1:0]   r_sr0_1;
  logic signed [AW-1:0]   r_prod [PT];

  // stage 2 / 3
  logic                   r_v2;
  logic signed [AW-1:0]   r_acc;
  logic signed [DW-1:0]   r_dout;
  logic                   r_dvld;

  logic signed [CW-1:0]   w_ctab [PT][L];
  logic signed [CW-1:0]   w_coef [PT];
  logic signed [AW-1:0]   w_sr_x [PT];
  logic signed [AW-1:0]   w_cf_x [PT];
  logic signed [AW-1:0]   w_prod [PT];
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_zoh;
  logic signed [AW-1:0]   w_acc;
  logic signed [AW-1:0]   w_rnd;
  logic signed [AW-1:0]   w_shf;
  logic signed [DW-1:0]   w_y;

  assign din_rdy   = !r_buf_full;
  assign w_wr      = din_vld && !r_buf_full;
  assign w_consume = cke && (r_ph == PW'(L - 1));
  assign w_starve  = w_consume && !r_buf_full && !din_vld;

  // Sample entering the delay line: buffered entry first, else a same-cycle bypass, else zero.
  always_comb begin
    w_new = '0;
    if (r_buf_full) begin
      w_new = r_buf;
    end else if (din_vld) begin
      w_new = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph       <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
      for (int k = 0; k < PT; k++) begin
        r_sr[k] <= '0;
      end
    end else begin
      if (cke) begin
        r_ph <= (r_ph == PW'(L - 1)) ? '0 : r_ph + PW'(1);
      end
      if (w_consume) begin
        for (int k = PT - 1; k > 0; k--) begin
          r_sr[k] <= r_sr[k-1];
        end
        r_sr[0] <= w_new;
      end
      if (w_consume) begin
        r_buf_full <= 1'b0;
      end else if (w_wr) begin
        r_buf      <= din;
        r_buf_full <= 1'b1;
      end
      if (w_starve) begin
        r_underrun <= 1'b1;
      end else if (clr_err) begin
        r_underrun <= 1'b0;
      end
    end
  end

  // Coefficient for delay-line slot gi at phase gj is tap[gj + gi*L]; unused indices read as 0.
  for (genvar gi = 0; gi < PT; gi++) begin : g_tap
    for (genvar gj = 0; gj < L; gj++) begin : g_ph
      if (gj + gi * L < N_TAPS) begin : g_used
        assign w_ctab[gi][gj] = tap[(gj + gi * L) * CW +: CW];
      end else begin : g_zero
        assign w_ctab[gi][gj] = '0;
      end
    end
    assign w_coef[gi] = w_ctab[gi][r_ph];
    assign w_sr_x[gi] = {{(AW-DW){r_sr[gi][DW-1]}}, r_sr[gi]};
    assign w_cf_x[gi] = {{(AW-CW){w_coef[gi][CW-1]}}, w_coef[gi]};
    assign w_prod[gi] = w_sr_x[gi] * w_cf_x[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_mode1 <= '0;
      r_ph0_1 <= 1'b0;
      r_sr0_1 <= '0;
      for (int k = 0; k < PT; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      r_v1 <= cke;
      if (cke) begin
        r_mode1 <= mode;
        r_ph0_1 <= (r_ph == '0);
        r_sr0_1 <= r_sr[0];
        for (int k = 0; k < PT; k++) begin
          r_prod[k] <= w_prod[k];
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < PT; k++) begin
      w_sum = w_sum + r_prod[k];
    end
  end

  assign w_zoh = {{(AW-DW){r_sr0_1[DW-1]}}, r_sr0_1} <<< FRAC;

  always_comb begin
    w_acc = w_sum;
    case (r_mode1)
      MODE_ZOH: w_acc = w_zoh;
      MODE_ZST: w_acc = r_ph0_1 ? w_zoh : '0;
      default:  w_acc = w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_acc <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_acc <= w_acc;
      end
    end
  end

  assign w_rnd = r_acc + HALF;
  assign w_shf = w_rnd >>> FRAC;

  always_comb begin
    w_y = w_shf[DW-1:0];
    if (w_shf > MAXV) begin
      w_y = MAXV[DW-1:0];
    end else if (w_shf < MINV) begin
      w_y = MINV[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_dvld <= 1'b0;
    end else begin
      r_dvld <= r_v2;
      if (r_v2) begin
        r_dout <= w_y;
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dvld;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fir_interp_poly.sv
// Randomized bench for fir_interp_poly: a sample-history / phase model predicts every output,
// the ready flag and the underrun flag; directed phases cover impulse, DC, saturation, starvation, modes.
module tb_fir_interp_poly;
  localparam int DW = 16, CW = 16, L = 10, PT = 5, NT = 41, FRAC = 15;

  logic clk = 1'b0;
  logic rst, cke, din_vld, din_rdy, clr_err, dout_vld, underrun;
  logic signed [DW-1:0] din, dout;
  logic [1:0] mode;
  logic [NT*CW-1:0] tap;

  always #5 clk = ~clk;

  fir_interp_poly #(.DW(DW), .CW(CW), .L(L), .PT(PT), .N_TAPS(NT), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .cke(cke), .din_vld(din_vld), .din_rdy(din_rdy), .din(din),
    .mode(mode), .tap(tap), .clr_err(clr_err), .dout(dout), .dout_vld(dout_vld),
    .underrun(underrun)
  );

  int n_chk = 0, n_err = 0, edge_n = 0, n_out = 0;
  int h [NT];
  int m_ph, m_pval, src_idx;
  bit m_pend, m_unr, m_took, rec_on;
  int m_hist [$];
  longint last_out;
  longint exp_val [$];
  int exp_due [$];
  longint rec_q [$];

  task automatic check_eq(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Expected output for one strobe, straight from the filter definition.
  function automatic longint model_out(int md);
    longint acc = 0, y;
    if (md == 1 || (md == 2 && m_ph == 0)) begin
      acc = longint'(m_hist[0]) * (longint'(1) << FRAC);
    end else if (md == 0 || md == 3) begin
      for (int k = 0; k < PT; k++) begin
        if (m_ph + k * L < NT) acc += longint'(m_hist[k]) * longint'(h[m_ph + k * L]);
      end
    end
    y = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic set_taps(int kind);
    for (int i = 0; i < NT; i++) begin
      case (kind)
        1: h[i] = 32'h0CCC;
        2: h[i] = 32'h7FFF;
        default: h[i] = int'($urandom_range(0, 65535)) - 32768;
      endcase
      tap[i*CW +: CW] = h[i][CW-1:0];
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_pend = 0; m_pval = 0; m_unr = 0; last_out = 0;
    m_hist.delete();
    for (int k = 0; k < PT; k++) m_hist.push_back(0);
    exp_val.delete(); exp_due.delete();
  endtask

  task automatic do_reset();
    rst = 1; cke = 0; din_vld = 0; clr_err = 0; din = '0; mode = '0;
    @(posedge clk); #1; edge_n++;
    rst = 0;
    model_reset();
    check_eq("rst_dout", dout, 0);
    check_eq("rst_dout_vld", dout_vld, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_din_rdy", din_rdy, 1);
  endtask

  task automatic step(bit c, bit v, int d, int md, bit clr);
    bit rdy, consumed, starve;
    int nw;
    longint ev;
    cke = c; din_vld = v; din = d[DW-1:0]; mode = md[1:0]; clr_err = clr;
    rdy = !m_pend; consumed = 0; starve = 0; nw = 0;
    m_took = v && rdy;
    if (c) begin
      exp_val.push_back(model_out(md));
      exp_due.push_back(edge_n + 3);
      if (m_ph == L - 1) begin
        consumed = 1;
        if (m_pend) begin nw = m_pval; m_pend = 0; end
        else if (v) nw = d;
        else starve = 1;
        m_hist.push_front(nw);
        void'(m_hist.pop_back());
      end
      m_ph = (m_ph + 1) % L;
    end
    if (v && rdy && !consumed) begin m_pend = 1; m_pval = d; end
    if (starve) m_unr = 1;
    else if (clr) m_unr = 0;
    @(posedge clk); #1; edge_n++;
    if (exp_due.size() > 0 && exp_due[0] == edge_n) begin
      ev = exp_val.pop_front();
      void'(exp_due.pop_front());
      n_out++;
      check_eq("dout_vld", dout_vld, 1);
      check_eq("dout", dout, ev);
      $display("out %0d edge %0d dout=%0d exp=%0d", n_out, edge_n, dout, ev);
      last_out = ev;
      if (rec_on) rec_q.push_back(longint'(dout));
    end else begin
      check_eq("dout_vld_idle", dout_vld, 0);
      check_eq("dout_hold", dout, last_out);
    end
    check_eq("din_rdy", din_rdy, !m_pend);
    check_eq("underrun", underrun, m_unr);
  endtask

  function automatic int sample(int kind, int idx);
    case (kind)
      0: return (idx == 0) ? 32'h4000 : 0;
      1: return 32'h7FFF;
      2: return -32768;
      3: return 32'h1234;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // md < 0 picks a random mode on every cycle.
  task automatic run(int n, int period, int vld_pct, int kind, int md, int clr_every);
    int m;
    src_idx = 0;
    for (int i = 0; i < n; i++) begin
      m = (md < 0) ? int'($urandom_range(0, 3)) : md;
      step((i % period) == 0, int'($urandom_range(0, 99)) < vld_pct, sample(kind, src_idx), m,
           clr_every > 0 && (i % clr_every) == 0);
      if (m_took) src_idx++;
    end
  endtask

  initial begin
    rst = 1; cke = 0; din_vld = 0; clr_err = 0; din = '0; mode = '0; tap = '0;
    rec_on = 0;
    set_taps(0);
    do_reset();

    // impulse: strobe every cycle, source always valid
    rec_on = 1;
    run(80, 1, 100, 0, 0, 0);
    rec_on = 0;
    for (int i = 0; i < NT; i++) begin
      check_eq("impulse", (rec_q.size() > L + i) ? rec_q[L + i] : 32'h7FFFFFFF, (h[i] + 1) >>> 1);
    end

    set_taps(1); do_reset();
    run(100, 1, 100, 1, 0, 0);

    set_taps(2);
    run(60, 1, 100, 1, 0, 0);
    run(60, 1, 100, 2, 0, 0);

    // starvation, then periodic clears while still starving
    run(40, 1, 0, 4, 0, 0);
    run(60, 1, 0, 4, 0, 7);

    do_reset();
    run(60, 1, 100, 3, 1, 0);
    run(60, 1, 100, 3, 2, 0);

    set_taps(0);
    run(200, 3, 50, 4, -1, 0);
    do_reset();
    run(200, 3, 60, 4, -1, 0);
    run(150, 1, 80, 4, -1, 13);
    run(150, 2, 30, 4, 0, 0);
    do_reset();
    run(100, 3, 50, 4, 0, 0);
    run(8, 100, 0, 4, 0, 0);
    check_eq("drain", exp_due.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
